// File: rtl/riscv_wb_stage_pkg.sv
// riscv_wb_stage_pkg: writeback result selects, load funct3 codes and FSM states
package riscv_wb_stage_pkg;
  typedef enum logic [2:0] {WB_X = 3'd0, WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
endpackage

// File: rtl/riscv_wb_stage_if.sv
// riscv_wb_stage_if: retire handshake, load response and register-file write bundle
interface riscv_wb_stage_if;
  import riscv_wb_stage_pkg::*;
  logic        in_valid;
  logic        in_ready;
  wb_sel_t     wb_sel;
  logic        rf_wen_in;
  logic [4:0]  rd_addr;
  logic [31:0] alu_out;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic [2:0]  mem_funct3;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  modport master (
    output in_valid, wb_sel, rf_wen_in, rd_addr, alu_out, pc, csr_rdata, mem_funct3,
           mem_resp_valid, mem_resp_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy
  );
  modport slave (
    input  in_valid, wb_sel, rf_wen_in, rd_addr, alu_out, pc, csr_rdata, mem_funct3,
           mem_resp_valid, mem_resp_data,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/riscv_wb_stage_load_ext.sv
// riscv_load_ext: selects and sign/zero-extends the addressed byte, halfword or word
module riscv_load_ext
  import riscv_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        legal
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LBU ? {24'b0, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'b0, h} :
           funct3 == F3_LW  ? word : '0;
  end
endmodule

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage: selects the retiring result, waits on load data, drives a registered rf write
module riscv_wb_stage
  import riscv_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst_n,
  riscv_wb_stage_if.slave bus
);
  state_t state, state_nx;
  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic wen_q, accept, eff_we, ld_legal;
  logic [31:0] ld_data;
  logic [XLEN-1:0] result;
  assign bus.in_ready = state != WAIT_MEM;
  assign bus.busy = state == WAIT_MEM;
  assign accept = bus.in_valid && bus.in_ready;
  assign eff_we = bus.rf_wen_in && bus.rd_addr != 5'd0 && bus.wb_sel != WB_X;
  assign result = bus.wb_sel == WB_PC4 ? bus.pc + 32'd4 :
                  bus.wb_sel == WB_CSR ? bus.csr_rdata : bus.alu_out;
  riscv_load_ext u_ext (
    .funct3(f3_q),
    .offset(off_q),
    .word(bus.mem_resp_data),
    .data(ld_data),
    .legal(ld_legal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = bus.wb_sel == WB_MEM ? WAIT_MEM : WRITE;
    else if (state == WAIT_MEM && bus.mem_resp_valid) state_nx = WRITE;
    else if (state == WRITE) state_nx = IDLE;
  end
  // a load's eff_we is parked in wen_q until its response arrives
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      wen_q <= 1'b0;
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (accept) begin
      rd_q <= bus.rd_addr;
      f3_q <= bus.mem_funct3;
      off_q <= bus.alu_out[1:0];
      wen_q <= eff_we;
      bus.rf_we <= eff_we && bus.wb_sel != WB_MEM;
      bus.rf_waddr <= bus.rd_addr;
      bus.rf_wdata <= result;
    end else if (state == WAIT_MEM && bus.mem_resp_valid) begin
      bus.rf_we <= wen_q && ld_legal;
      bus.rf_waddr <= rd_q;
      bus.rf_wdata <= ld_data;
    end else begin
      bus.rf_we <= 1'b0;
    end
endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb_riscv_wb_stage: scoreboard bench for the writeback stage
module tb_riscv_wb_stage;
  import riscv_wb_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [36:0] sb[$];
  riscv_wb_stage_if bus ();
  riscv_wb_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [32:0] ld_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    case (f3)
      3'b000: return {1'b1, {24{s[7]}}, s[7:0]};
      3'b100: return {1'b1, 24'b0, s[7:0]};
      3'b010: return {1'b1, w};
      3'b001: begin s = w >> (off[1] ? 16 : 0); return {1'b1, {16{s[15]}}, s[15:0]}; end
      3'b101: begin s = w >> (off[1] ? 16 : 0); return {1'b1, 16'b0, s[15:0]}; end
      default: return 33'b0;
    endcase
  endfunction

  always @(negedge clk)
    if (rst_n && bus.rf_we) begin
      if (sb.size() == 0) check("spurious_we", {31'b0, bus.rf_we}, 32'd0);
      else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("wb_addr", {27'b0, bus.rf_waddr}, {27'b0, e[36:32]});
        check("wb_data", bus.rf_wdata, e[31:0]);
      end
    end

  task automatic send(input wb_sel_t sel, input logic wen, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] pcv, input logic [31:0] csr,
                      input logic [2:0] f3);
    int n = 0;
    logic [31:0] r;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.wb_sel = sel; bus.rf_wen_in = wen; bus.rd_addr = rd; bus.alu_out = alu;
    bus.pc = pcv; bus.csr_rdata = csr; bus.mem_funct3 = f3; bus.in_valid = 1'b1;
    r = sel == WB_PC4 ? pcv + 32'd4 : sel == WB_CSR ? csr : alu;
    if (sel != WB_MEM && sel != WB_X && wen && rd != 0) sb.push_back({rd, r});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic wen, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] w, input int dly);
    logic [32:0] m;
    logic eff;
    m = ld_model(f3, addr[1:0], w);
    eff = wen && rd != 0 && m[32];
    send(WB_MEM, wen, rd, addr, 32'h0, 32'h0, f3);
    check("ld_busy", {31'b0, bus.busy}, 32'd1);
    check("ld_not_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (dly - 1) @(negedge clk);
    if (dly > 1) check("ld_busy_wait", {31'b0, bus.busy}, 32'd1);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = w;
    if (eff) sb.push_back({rd, m[31:0]});
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = $urandom;
    check("ld_we", {31'b0, bus.rf_we}, {31'b0, eff});
    if (!m[32]) check("ld_illegal_data", bus.rf_wdata, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_we"}, {31'b0, bus.rf_we}, 32'd0);
    check({tag, "_waddr"}, {27'b0, bus.rf_waddr}, 32'd0);
    check({tag, "_wdata"}, bus.rf_wdata, 32'd0);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid = 0; bus.wb_sel = WB_X; bus.rf_wen_in = 0; bus.rd_addr = 0; bus.alu_out = 0;
    bus.pc = 0; bus.csr_rdata = 0; bus.mem_funct3 = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");
    send(WB_ALU, 1, 5, 32'h1234_5678, 32'h0, 32'h0, 3'b0);
    check("b2b_we0", {31'b0, bus.rf_we}, 32'd1);
    check("b2b_ready0", {31'b0, bus.in_ready}, 32'd1);
    send(WB_PC4, 1, 6, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b0);
    check("b2b_we1", {31'b0, bus.rf_we}, 32'd1);
    check("b2b_ready1", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_idle_we", {31'b0, bus.rf_we}, 32'd0);
    send(WB_CSR, 1, 31, 32'h0, 32'h0, 32'hCAFE_F00D, 3'b0);
    load(1, 7, 32'h1003, F3_LB, 32'h80FF_0011, 3);
    load(1, 8, 32'h1003, F3_LBU, 32'h80FF_0011, 3);
    load(1, 9, 32'h1002, F3_LH, 32'h8001_7FFF, 1);
    load(1, 10, 32'h1002, F3_LHU, 32'h8001_7FFF, 2);
    load(1, 11, 32'h1000, F3_LW, 32'hA5A5_5A5A, 1);
    send(WB_ALU, 1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b0);
    check("rd0_we", {31'b0, bus.rf_we}, 32'd0);
    send(WB_X, 1, 12, 32'h1111_1111, 32'h0, 32'h0, 3'b0);
    check("wbx_we", {31'b0, bus.rf_we}, 32'd0);
    load(1, 13, 32'h2000, 3'b011, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    check("illegal_idle_ready", {31'b0, bus.in_ready}, 32'd1);
    check("illegal_idle_busy", {31'b0, bus.busy}, 32'd0);
    load(0, 14, 32'h2004, F3_LW, 32'h1234_0000, 2);
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("stray_resp_we", {31'b0, bus.rf_we}, 32'd0);
    check("stray_resp_ready", {31'b0, bus.in_ready}, 32'd1);
    send(WB_MEM, 1, 15, 32'h3000, 32'h0, 32'h0, F3_LW);
    rst_n = 1'b0;
    #1 check("rst_wait_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 32'h7777_7777;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("rst_late_we", {31'b0, bus.rf_we}, 32'd0);
    check("rst_late_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 24; i++) begin
      logic [2:0] f3s[5];
      f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      if ($urandom_range(0, 1)) load(1, 5'($urandom_range(1, 31)), $urandom, f3s[$urandom_range(0, 4)],
                                     $urandom, $urandom_range(1, 3));
      else send(wb_sel_t'($urandom_range(1, 4) == 2 ? 1 : $urandom_range(3, 4)), 1,
                5'($urandom), $urandom, $urandom, $urandom, 3'b0);
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
